soc_system_key_debounce: RTL and testbench
==========================================

Name: soc_system_key_debounce

Overview:
Conditions one raw pushbutton pin (Bluetooth pairing key) before it reaches the key PIO's in_port. Synchronises the asynchronous pin, debounces it with a confirm-counter state machine, and outputs a clean active-high pressed level. Also provides single-cycle press/release pulses, a long-press flag and a wrapping press counter for status/IRQ logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on key_raw (legal range 2..4)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz; minimum 2)
LONG_PRESS_CYCLES, 100000000, cycles key_out must stay high before long_press asserts (2 s at 50 MHz; minimum 2)
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed

Ports:
clk  input  1  system clock; sole clock domain
reset_n  input  1  asynchronous active-low reset
key_raw  input  1  raw pushbutton pin; asynchronous, bouncing
key_out  output  1  debounced level, 1 = pressed; drives key PIO in_port
press_pulse  output  1  one-cycle pulse when a press is accepted
release_pulse  output  1  one-cycle pulse when a release is accepted
long_press  output  1  level; high while held beyond LONG_PRESS_CYCLES
press_count  output  8  accepted-press count, wraps 255 -> 0

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. Ports are named clk and reset_n.
- Reset values:
  - key_out, press_pulse, release_pulse and long_press are 0; press_count is 0.
  - All synchroniser flops reset to the inactive pin level: 1 if ACTIVE_LOW, else 0.
  - State is RELEASED; all counters are 0.
- Synchroniser: key_raw passes through SYNC_STAGES flops. Its output is normalised to k_s, where 1 = pressed (inverted when ACTIVE_LOW).
- Debounce counter: width is $clog2(DEBOUNCE_CYCLES). The hold counter is $clog2(LONG_PRESS_CYCLES) wide and saturates.
- States and transitions (all evaluated on the rising edge of clk):
  - RELEASED: if k_s=1, go to CONFIRM_PRESS with cnt=1; otherwise cnt=0.
  - CONFIRM_PRESS:
    - if k_s=0, go to RELEASED with cnt=0 (bounce restarts qualification);
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set key_out=1, press_pulse=1, press_count+=1, hold=0;
    - else cnt+=1.
  - PRESSED:
    - if k_s=0, go to CONFIRM_RELEASE with cnt=1;
    - else hold+=1 (saturating). long_press is set on the edge where hold==LONG_PRESS_CYCLES-1.
  - CONFIRM_RELEASE:
    - if k_s=1, go back to PRESSED with cnt=0. hold is not cleared and keeps counting, so a release glitch does not restart long-press timing.
    - else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED, set key_out=0, release_pulse=1, long_press=0;
    - else cnt+=1.
- Latency: a clean edge on key_raw reaches key_out exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges later.
  - Pulses are high for exactly the one cycle following the key_out transition edge; they are registered, never combinational.
- long_press: rises exactly LONG_PRESS_CYCLES edges after key_out rises, if the key is continuously pressed. It falls on the same edge key_out falls.
- press_count: modulo-256; 255 -> 0 on the next press with no flag.
- Simultaneous events: cannot occur by construction; press and release pulses are mutually exclusive.
- Reset mid-operation: all outputs go to their reset values immediately, with no pulse on reset release.
  - If the key is held through reset, a fresh press is accepted SYNC_STAGES+DEBOUNCE_CYCLES edges after reset_n rises, and press_count becomes 1.

Test Plan:
(bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1)
1. Clean press: key_raw 1->0 and held -> key_out=1 on the 6th edge; press_pulse high one cycle; press_count=1; no release_pulse.
2. Press bounce: key_raw low 3 cycles, high 1 cycle, then low held -> key_out stays 0 until the 6th edge after the final falling transition; exactly one press_pulse.
3. Release glitch: with key_out=1, drive key_raw high 2 cycles then low -> key_out stays 1; no pulses; long_press timing is not restarted.
4. Long press: hold key -> long_press=1 exactly 10 edges after key_out rose. Then release -> key_out=0 and long_press=0 together, 6 edges after key_raw rises; release_pulse high one cycle.
5. Wrap: perform 256 clean press/release cycles -> press_count reads 255 after the 255th press and 0 after the 256th; 256 press_pulses counted.
6. Reset mid-confirm: assert reset_n=0 during CONFIRM_PRESS -> all outputs 0 immediately. Keep key held and release reset -> key_out=1 on the 6th edge after reset release; press_count=1.

Source files
------------

// File: rtl/soc_system_key_debounce.sv
// Pushbutton conditioner for the pairing key: synchroniser, confirm-counter
// debounce FSM, registered press/release pulses, long-press flag and press count.
//
// state           | meaning
// ----------------|--------------------------------------------------------
// ST_RELEASED     | key accepted as released, waiting for a pressed sample
// ST_CONFIRM_PRESS| pressed seen, counting stable cycles before accepting
// ST_PRESSED      | key accepted as pressed, hold timer running
// ST_CONFIRM_REL  | released seen, counting stable cycles before accepting
module soc_system_key_debounce #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_raw,
  output logic       key_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);

  localparam logic          IDLE_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_CONFIRM_PRESS = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_CONFIRM_REL   = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic [HW-1:0]          hold;
  logic                   k_s;

  // Synchroniser flops idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign k_s = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RELEASED;
      cnt           <= '0;
      hold          <= '0;
      key_out       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (k_s) begin
            state <= ST_CONFIRM_PRESS;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_CONFIRM_PRESS: begin
          if (!k_s) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_PRESSED;
            cnt         <= '0;
            hold        <= '0;
            key_out     <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (hold != HOLD_LAST) begin
            hold <= hold + HOLD_ONE;
          end
          if (!k_s) begin
            state <= ST_CONFIRM_REL;
            cnt   <= CNT_ONE;
          end else if (hold == HOLD_LAST) begin
            long_press <= 1'b1;
          end
        end
        ST_CONFIRM_REL: begin
          // Hold keeps running here so a release glitch does not restart long-press timing.
          if (hold != HOLD_LAST) begin
            hold <= hold + HOLD_ONE;
          end
          if (k_s) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            key_out       <= 1'b0;
            release_pulse <= 1'b1;
            long_press    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_key_debounce.sv
// Scoreboard bench for the key debouncer: stimulus pushes expected events
// (kind, cycle, count), a negedge monitor pops and compares them.
module tb_soc_system_key_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int LAT  = SYNC + DEB;

  localparam int EV_PRESS     = 0;
  localparam int EV_RELEASE   = 1;
  localparam int EV_LONG_RISE = 2;
  localparam int EV_LONG_FALL = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_raw = 1'b1;
  logic       key_out;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  soc_system_key_debounce #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LONG),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .key_out(key_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  exp_cnt = 0;
  int  n_press_seen = 0;
  logic long_prev = 1'b0;

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic expect_ev(int kind, int at, int cnt);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic consume(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_cycle", cyc, e.at);
    if (kind == EV_PRESS) chk("ev_press_count", int'(press_count), e.cnt);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (press_pulse) begin
        n_press_seen++;
        chk("press_key_out", int'(key_out), 1);
        consume(EV_PRESS);
      end
      if (release_pulse) begin
        chk("release_key_out", int'(key_out), 0);
        consume(EV_RELEASE);
      end
      if (long_press && !long_prev) consume(EV_LONG_RISE);
      if (!long_press && long_prev) consume(EV_LONG_FALL);
    end
    long_prev = long_press;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_key_out"}, int'(key_out), 0);
    chk({tag, "_press_pulse"}, int'(press_pulse), 0);
    chk({tag, "_release_pulse"}, int'(release_pulse), 0);
    chk({tag, "_long_press"}, int'(long_press), 0);
    chk({tag, "_press_count"}, int'(press_count), 0);
  endtask

  task automatic press_release();
    step(1);
    key_raw = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    expect_ev(EV_PRESS, cyc + LAT, exp_cnt);
    drain(40);
    step(1);
    key_raw = 1'b1;
    expect_ev(EV_RELEASE, cyc + LAT, 0);
    drain(40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k_rise;
    int base;

    step(2);
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(3);
    chk("idle_key_out", int'(key_out), 0);

    // clean press and release
    press_release();
    chk("t1_count", int'(press_count), 1);

    // press with one bounce: qualification restarts from the last falling edge
    step(1);
    key_raw = 1'b0;
    step(3);
    key_raw = 1'b1;
    step(1);
    key_raw = 1'b0;
    chk("t2_key_out_bounce", int'(key_out), 0);
    exp_cnt++;
    expect_ev(EV_PRESS, cyc + LAT, exp_cnt);
    drain(40);
    chk("t2_count", int'(press_count), 2);
    step(1);
    key_raw = 1'b1;
    expect_ev(EV_RELEASE, cyc + LAT, 0);
    drain(40);

    // press, release glitch, then long press timed from the original press
    step(1);
    key_raw = 1'b0;
    exp_cnt++;
    k_rise = cyc + LAT;
    expect_ev(EV_PRESS, k_rise, exp_cnt);
    drain(40);
    step(1);
    key_raw = 1'b1;
    step(2);
    key_raw = 1'b0;
    expect_ev(EV_LONG_RISE, k_rise + LONG, 0);
    step(4);
    chk("t3_key_out_held", int'(key_out), 1);
    drain(40);
    chk("t4_long_level", int'(long_press), 1);
    step(1);
    key_raw = 1'b1;
    expect_ev(EV_RELEASE, cyc + LAT, 0);
    expect_ev(EV_LONG_FALL, cyc + LAT, 0);
    drain(40);
    chk("t4_key_out_released", int'(key_out), 0);
    chk("t4_count", int'(press_count), 3);

    // reset during confirm, key held through reset
    step(1);
    key_raw = 1'b0;
    step(4);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    exp_cnt = 1;
    expect_ev(EV_PRESS, cyc + LAT, exp_cnt);
    drain(40);
    chk("t6_count", int'(press_count), 1);
    step(1);
    key_raw = 1'b1;
    expect_ev(EV_RELEASE, cyc + LAT, 0);
    drain(40);

    // 256 presses from a fresh reset: count wraps to zero
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    exp_cnt = 0;
    base = n_press_seen;
    for (int i = 1; i <= 256; i++) begin
      press_release();
      if (i == 255) chk("wrap_255", int'(press_count), 255);
    end
    chk("wrap_0", int'(press_count), 0);
    chk("wrap_pulses", n_press_seen - base, 256);

    step(10);
    drain(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
